// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the hazard scoreboard: tracker entry layout and
// the forwarding-select encoding.
package hazard_scoreboard_pkg;

  // Tags are stored zero-extended to TAG_MAX bits so the entry type is fixed-width.
  localparam int TAG_MAX     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] dest;
    logic               is_load;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '{valid: 1'b0, dest: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Priority match of one source tag against the tracker; the youngest
// (lowest-index) matching entry wins.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1]    entries,
  input  logic [TAG_MAX-1:0]  src,
  input  logic                en,
  output logic                hit,
  output logic [SEL_W-1:0]    sel,
  output logic                is_load
);

  always_comb begin
    hit     = 1'b0;
    sel     = SEL_W'(FWD_REGFILE);
    is_load = 1'b0;
    // Scan oldest to youngest so the last assignment is the youngest match.
    for (int k = DEPTH; k >= 1; k--) begin
      if (en && entries[k].valid && (entries[k].dest == src)) begin
        hit     = 1'b1;
        sel     = SEL_W'(k);
        is_load = entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight writers past decode and produces
// stall and operand-forwarding selects for the instruction in ID.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  REG_BITS   = 4,
  parameter int  DEPTH      = 2,
  parameter int  FORWARD_EN = 1,
  parameter int  LOAD_READY = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_src1,
  input  logic [REG_BITS-1:0] id_src2,
  input  logic                id_has_two_src,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                flush,
  output logic                stall,
  output logic [SEL_W-1:0]    fwd_sel1,
  output logic [SEL_W-1:0]    fwd_sel2,
  output logic [SEL_W-1:0]    inflight_cnt,
  output logic [15:0]         stall_cycles
);

  localparam logic [SEL_W-1:0] LOAD_READY_SEL = SEL_W'(LOAD_READY);

  entry_t [DEPTH:1] ent;
  entry_t [DEPTH:1] ent_nxt;
  logic [SEL_W-1:0] cnt_nxt;
  logic             hit1, hit2, ld1, ld2, hazard;
  logic [SEL_W-1:0] sel1_m, sel2_m;

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
    .entries (ent),
    .src     (TAG_MAX'(id_src1)),
    .en      (1'b1),
    .hit     (hit1),
    .sel     (sel1_m),
    .is_load (ld1)
  );

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match2 (
    .entries (ent),
    .src     (TAG_MAX'(id_src2)),
    .en      (id_has_two_src),
    .hit     (hit2),
    .sel     (sel2_m),
    .is_load (ld2)
  );

  always_comb begin
    if (FORWARD_EN == 0) begin
      hazard = hit1 | hit2;
    end else begin
      // Load data only becomes forwardable once the load reaches LOAD_READY.
      hazard = (hit1 && ld1 && (sel1_m < LOAD_READY_SEL)) ||
               (hit2 && ld2 && (sel2_m < LOAD_READY_SEL));
    end
  end

  assign stall    = hazard & id_valid & ~flush;
  assign fwd_sel1 = ((FORWARD_EN != 0) && !stall) ? sel1_m : SEL_W'(FWD_REGFILE);
  assign fwd_sel2 = ((FORWARD_EN != 0) && !stall) ? sel2_m : SEL_W'(FWD_REGFILE);

  always_comb begin
    ent_nxt = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      ent_nxt[k] = ent[k-1];
    end
    ent_nxt[1] = ENTRY_BUBBLE;
    if (id_valid && id_wb_en && !stall && !flush) begin
      ent_nxt[1] = '{valid: 1'b1, dest: TAG_MAX'(id_dest), is_load: id_mem_r_en};
    end
    cnt_nxt = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      cnt_nxt = cnt_nxt + SEL_W'(ent_nxt[k].valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent          <= '0;
      inflight_cnt <= '0;
      stall_cycles <= '0;
    end else begin
      ent          <= ent_nxt;
      inflight_cnt <= cnt_nxt;
      if (stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a forwarding instance, a no-forwarding instance and a
// deep no-forwarding instance share one ID stimulus stream.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_has_two_src, id_wb_en, id_mem_r_en, flush;
  logic [3:0] id_src1, id_src2, id_dest;

  logic       stall_f, stall_n, stall_d;
  logic [1:0] sel1_f, sel2_f, cnt_f, sel1_n, sel2_n, cnt_n;
  logic [3:0] sel1_d, sel2_d, cnt_d;
  logic [15:0] sc_f, sc_n, sc_d;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       stall_f;
    logic [1:0] sel1_f;
    logic [1:0] sel2_f;
    logic       stall_n;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_BITS(4), .DEPTH(2), .FORWARD_EN(1), .LOAD_READY(2)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_two_src(id_has_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .flush(flush), .stall(stall_f), .fwd_sel1(sel1_f),
    .fwd_sel2(sel2_f), .inflight_cnt(cnt_f), .stall_cycles(sc_f)
  );

  hazard_scoreboard #(.REG_BITS(4), .DEPTH(2), .FORWARD_EN(0), .LOAD_READY(2)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_two_src(id_has_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .flush(flush), .stall(stall_n), .fwd_sel1(sel1_n),
    .fwd_sel2(sel2_n), .inflight_cnt(cnt_n), .stall_cycles(sc_n)
  );

  hazard_scoreboard #(.REG_BITS(4), .DEPTH(8), .FORWARD_EN(0), .LOAD_READY(2)) dut_deep (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_has_two_src(id_has_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .flush(flush), .stall(stall_d), .fwd_sel1(sel1_d),
    .fwd_sel2(sel2_d), .inflight_cnt(cnt_d), .stall_cycles(sc_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic ld,
                       input logic [3:0] d, input logic fl);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_has_two_src = two;
    id_wb_en = wb; id_mem_r_en = ld; id_dest = d; flush = fl;
  endtask

  // One ID cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                      input logic two, input logic wb, input logic ld,
                      input logic [3:0] d, input logic fl,
                      input logic e_stall_f, input logic [1:0] e_s1f, input logic [1:0] e_s2f,
                      input logic e_stall_n, input logic [1:0] e_cnt, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v, s1, s2, two, wb, ld, d, fl);
    exp_q.push_back('{tag: tag, stall_f: e_stall_f, sel1_f: e_s1f, sel2_f: e_s2f,
                      stall_n: e_stall_n, cnt: e_cnt});
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, ".stall_f"}, 32'(stall_f), 32'(e.stall_f));
    check({e.tag, ".sel1_f"},  32'(sel1_f),  32'(e.sel1_f));
    check({e.tag, ".sel2_f"},  32'(sel2_f),  32'(e.sel2_f));
    check({e.tag, ".stall_n"}, 32'(stall_n), 32'(e.stall_n));
    check({e.tag, ".sel_n"},   32'({sel1_n, sel2_n}), 32'(0));
    check({e.tag, ".cnt_f"},   32'(cnt_f),   32'(e.cnt));
    check({e.tag, ".cnt_n"},   32'(cnt_n),   32'(e.cnt));
  endtask

  task automatic idle(input logic [1:0] e_cnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_cnt, "idle");
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst.stall", 32'({stall_f, stall_n, stall_d}), 32'(0));
    check("rst.sel",   32'({sel1_f, sel2_f, sel1_d, sel2_d}), 32'(0));
    check("rst.cnt",   32'({cnt_f, cnt_n, cnt_d}), 32'(0));
    check("rst.sc",    32'(sc_f | sc_n | sc_d), 32'(0));
    #1 rst = 1'b1;

    // ALU writer r3, then readers in the next three cycles
    step(1, 0, 0, 0, 1, 0, 3, 0,  0, 0, 0, 0, 0, "w_r3");
    step(1, 3, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, "rd_r3_a");
    step(1, 3, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 1, "rd_r3_b");
    step(1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "rd_r3_c");
    check("sc_f.alu", 32'(sc_f), 32'(0));
    check("sc_n.alu", 32'(sc_n), 32'(2));

    // load-use on src1
    step(1, 0, 0, 0, 1, 1, 2, 0,  0, 0, 0, 0, 0, "ld_r2");
    step(1, 2, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, "lu_a");
    step(1, 2, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 1, "lu_b");
    idle(0);
    check("sc_f.lu", 32'(sc_f), 32'(1));
    check("sc_n.lu", 32'(sc_n), 32'(4));

    // two writers of r7: youngest wins; src2 ignored when not read
    step(1, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 0, 0, "w_r7_a");
    step(1, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 0, 1, "w_r7_b");
    step(1, 7, 7, 1, 0, 0, 0, 0,  0, 1, 1, 1, 2, "rd_r7_pair");
    step(1, 1, 7, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, "src2_off");

    // flush wins over a hazard and inserts a bubble
    step(1, 0, 0, 0, 1, 0, 4, 0,  0, 0, 0, 0, 0, "w_r4");
    step(1, 4, 0, 0, 1, 0, 9, 1,  0, 1, 0, 0, 1, "flush_hz");
    idle(1);
    idle(0);
    check("sc_f.flush", 32'(sc_f), 32'(1));
    check("sc_n.flush", 32'(sc_n), 32'(5));

    // load-use through src2, then a non-valid ID slot
    step(1, 0, 0, 0, 1, 1, 6, 0,  0, 0, 0, 0, 0, "ld_r6");
    step(1, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, "lu_src2_a");
    step(1, 1, 6, 1, 0, 0, 0, 0,  0, 0, 2, 1, 1, "lu_src2_b");
    step(1, 0, 0, 0, 1, 0, 8, 0,  0, 0, 0, 0, 0, "w_r8");
    step(0, 8, 0, 0, 1, 0, 5, 0,  0, 1, 0, 0, 1, "novalid");
    idle(1);
    idle(0);
    check("sc_f.src2", 32'(sc_f), 32'(2));
    check("sc_n.src2", 32'(sc_n), 32'(7));

    // asynchronous reset in the middle of a stall
    step(1, 0, 0, 0, 1, 0, 3, 0,  0, 0, 0, 0, 0, "w_r3_again");
    step(1, 3, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, "pre_rst");
    rst = 1'b0;
    #1;
    check("midrst.stall", 32'({stall_f, stall_n, stall_d}), 32'(0));
    check("midrst.sel_f", 32'(sel1_f), 32'(0));
    check("midrst.cnt",   32'({cnt_f, cnt_n, cnt_d}), 32'(0));
    check("midrst.sc",    32'(sc_f | sc_n | sc_d), 32'(0));
    #1 rst = 1'b1;
    step(1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, "post_rst");

    // deep instance: one writer of r1 then 8 readers, repeated until saturation
    for (int p = 0; p < 8300; p++) begin
      for (int c = 0; c < 9; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) drive(1, 2, 0, 0, 1, 0, 1, 0);
        else        drive(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        if (p == 0 && c == 8) begin
          check("deep.oldest_stall", 32'(stall_d), 32'(1));
          check("deep.oldest_cnt",   32'(cnt_d),   32'(1));
          check("deep.sel",          32'({sel1_d, sel2_d}), 32'(0));
        end
        if (p == 1 && c == 0) begin
          check("deep.drained_stall", 32'(stall_d), 32'(0));
          check("deep.drained_cnt",   32'(cnt_d),   32'(0));
          check("deep.sc_period",     32'(sc_d),    32'(8));
        end
      end
    end
    check("deep.sc_sat",   32'(sc_d),    32'(16'hFFFF));
    check("deep.cnt_end",  32'(cnt_d),   32'(1));
    rst = 1'b0;
    #1;
    check("satrst.sc",    32'(sc_d),    32'(0));
    check("satrst.cnt",   32'(cnt_d),   32'(0));
    check("satrst.stall", 32'(stall_d), 32'(0));
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
